// File: rtl/aes_sbox_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_scheduler
// Brief    : Shares one external 4-lane S-box bank between state SubBytes
//            (four beats) and key-schedule SubWord (one beat). Optional macro
//            SBOX_PREEMPT_EN lets one key word cut into a running state op.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_scheduler (
    input  logic         clk,
    input  logic         resetn,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         kw_out_valid,
    output logic [31:0]  kw_out,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_BEAT  = 2'd1;
    localparam logic [1:0] c_KW_BEAT  = 2'd2;
    localparam logic       c_GRANT_ST = 1'b0;
    localparam logic       c_GRANT_KW = 1'b1;

    logic [1:0]   state_q,      state_d;
    logic [1:0]   beat_q,       beat_d;
    logic         last_grant_q, last_grant_d;
    logic         preempted_q,  preempted_d;
    logic [127:0] st_cap_q,     st_cap_d;
    logic [31:0]  kw_cap_q,     kw_cap_d;
    logic [127:0] st_out_q,     st_out_d;
    logic [31:0]  kw_out_q,     kw_out_d;
    logic         st_done_q,    st_done_d;
    logic         kw_done_q,    kw_done_d;

    logic         w_idle;
    logic         w_st_grant;
    logic         w_kw_grant;
    logic         w_kw_preempt;

    assign w_idle = (state_q == c_IDLE);

`ifdef SBOX_PREEMPT_EN
    assign w_kw_preempt = (state_q == c_ST_BEAT) && (beat_q != 2'd3) &&
                          !preempted_q && kw_valid;
`else
    assign w_kw_preempt = 1'b0;
`endif

    // Round-robin on contention: the side that did not win last time goes next.
    assign w_st_grant = resetn && w_idle && st_valid &&
                        (!kw_valid || (last_grant_q == c_GRANT_KW));
    assign w_kw_grant = resetn &&
                        ((w_idle && kw_valid && (!st_valid || (last_grant_q == c_GRANT_ST))) ||
                         w_kw_preempt);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        preempted_d  = preempted_q;
        st_cap_d     = st_cap_q;
        kw_cap_d     = kw_cap_q;
        st_out_d     = st_out_q;
        kw_out_d     = kw_out_q;
        st_done_d    = 1'b0;
        kw_done_d    = 1'b0;

        if (w_st_grant) begin
            st_cap_d     = st_data;
            last_grant_d = c_GRANT_ST;
        end
        if (w_kw_grant) begin
            kw_cap_d     = kw_data;
            last_grant_d = c_GRANT_KW;
        end

        case (state_q)
            c_IDLE: begin
                beat_d = 2'd0;
                if (w_st_grant) begin
                    state_d = c_ST_BEAT;
                end else if (w_kw_grant) begin
                    state_d = c_KW_BEAT;
                end
            end
            c_ST_BEAT: begin
                st_out_d[{beat_q, 5'd0} +: 32] = sb_out;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d     = c_IDLE;
                    st_done_d   = 1'b1;
                    preempted_d = 1'b0;
                end else if (w_kw_preempt) begin
                    state_d     = c_KW_BEAT;
                    preempted_d = 1'b1;
                end
            end
            c_KW_BEAT: begin
                kw_out_d  = sb_out;
                kw_done_d = 1'b1;
                // A preempting key beat hands the bank back to the paused state op.
                state_d   = preempted_q ? c_ST_BEAT : c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= c_IDLE;
            beat_q       <= 2'd0;
            last_grant_q <= c_GRANT_KW;
            preempted_q  <= 1'b0;
            st_cap_q     <= '0;
            kw_cap_q     <= '0;
            st_out_q     <= '0;
            kw_out_q     <= '0;
            st_done_q    <= 1'b0;
            kw_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            preempted_q  <= preempted_d;
            st_cap_q     <= st_cap_d;
            kw_cap_q     <= kw_cap_d;
            st_out_q     <= st_out_d;
            kw_out_q     <= kw_out_d;
            st_done_q    <= st_done_d;
            kw_done_q    <= kw_done_d;
        end
    end

    always_comb begin
        sb_in = 32'd0;
        case (state_q)
            c_ST_BEAT: sb_in = st_cap_q[{beat_q, 5'd0} +: 32];
            c_KW_BEAT: sb_in = kw_cap_q;
            default:   sb_in = 32'd0;
        endcase
    end

    assign st_ready     = w_st_grant;
    assign kw_ready     = w_kw_grant;
    assign st_out       = st_out_q;
    assign kw_out       = kw_out_q;
    assign st_out_valid = st_done_q;
    assign kw_out_valid = kw_done_q;
    assign busy         = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sbox_scheduler
// Brief    : Randomised bench for aes_sbox_scheduler with a transaction-level
//            reference model and a GF(2^8)-derived S-box bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_scheduler;

    logic         clk = 1'b0;
    logic         resetn;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_data;
    logic         st_out_valid;
    logic [127:0] st_out;
    logic         kw_valid;
    logic         kw_ready;
    logic [31:0]  kw_data;
    logic         kw_out_valid;
    logic [31:0]  kw_out;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sbox_t [256];

    aes_sbox_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_data      (st_data),
        .st_out_valid (st_out_valid),
        .st_out       (st_out),
        .kw_valid     (kw_valid),
        .kw_ready     (kw_ready),
        .kw_data      (kw_data),
        .kw_out_valid (kw_out_valid),
        .kw_out       (kw_out),
        .sb_in        (sb_in),
        .sb_out       (sb_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        sb_out = {sbox_t[sb_in[31:24]], sbox_t[sb_in[23:16]],
                  sbox_t[sb_in[15:8]],  sbox_t[sb_in[7:0]]};
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'd0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        t = t << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'd1;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub128(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_t[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_t[d[8*i +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference model: operations are tracked as accept cycles and due cycles.
    int           cyc;
    int           free_at;
    int           st_acc;
    int           st_done_at;
    int           kw_done_at;
    int           kw_beat_at;
    bit           st_pre;
    bit           last_kw;
    logic [127:0] st_cap_m, st_pend, st_cur;
    logic [31:0]  kw_cap_m, kw_pend, kw_cur;

    task automatic model_reset();
        st_acc     = -1000;
        st_done_at = -1000;
        kw_done_at = -1000;
        kw_beat_at = -1000;
        st_pre     = 1'b0;
        last_kw    = 1'b1;
        st_cur     = '0;
        kw_cur     = '0;
        st_cap_m   = '0;
        kw_cap_m   = '0;
    endtask

    task automatic model_step();
        bit          idle_m;
        bit          exp_sr;
        bit          exp_kr;
        int          k;
        logic [31:0] exp_sb;
        idle_m = (cyc >= free_at);
        if (cyc == st_done_at) st_cur = st_pend;
        if (cyc == kw_done_at) kw_cur = kw_pend;

        exp_sr = 1'b0;
        exp_kr = 1'b0;
        if (resetn) begin
            if (idle_m) begin
                if (st_valid && kw_valid) begin
                    exp_sr = last_kw;
                    exp_kr = !last_kw;
                end else begin
                    exp_sr = st_valid;
                    exp_kr = kw_valid;
                end
            end
`ifdef SBOX_PREEMPT_EN
            else if (!st_pre && (cyc - st_acc >= 1) && (cyc - st_acc <= 3) && kw_valid) begin
                exp_kr = 1'b1;
            end
`endif
        end

        if (idle_m) begin
            exp_sb = 32'd0;
        end else if (cyc == kw_beat_at) begin
            exp_sb = kw_cap_m;
        end else begin
            k = cyc - st_acc - 1 - ((st_pre && cyc > kw_beat_at) ? 1 : 0);
            exp_sb = 32'(st_cap_m >> (32 * k));
        end

        check("busy",         {127'd0, busy},         {127'd0, !idle_m});
        check("st_ready",     {127'd0, st_ready},     {127'd0, exp_sr});
        check("kw_ready",     {127'd0, kw_ready},     {127'd0, exp_kr});
        check("sb_in",        {96'd0, sb_in},         {96'd0, exp_sb});
        check("st_out_valid", {127'd0, st_out_valid}, {127'd0, cyc == st_done_at});
        check("kw_out_valid", {127'd0, kw_out_valid}, {127'd0, cyc == kw_done_at});
        check("kw_out",       {96'd0, kw_out},        {96'd0, kw_cur});
        if (idle_m) check("st_out", st_out, st_cur);

        if (!resetn) begin
            model_reset();
            free_at = cyc + 1;
        end else begin
            if (exp_sr) begin
                st_acc     = cyc;
                st_pre     = 1'b0;
                st_cap_m   = st_data;
                st_pend    = sub128(st_data);
                st_done_at = cyc + 5;
                free_at    = cyc + 5;
                last_kw    = 1'b0;
            end
            if (exp_kr) begin
                kw_cap_m   = kw_data;
                kw_pend    = sub32(kw_data);
                kw_beat_at = cyc + 1;
                kw_done_at = cyc + 2;
                last_kw    = 1'b1;
                if (!idle_m) begin
                    st_pre     = 1'b1;
                    st_done_at = st_done_at + 1;
                    free_at    = free_at + 1;
                end else begin
                    free_at = cyc + 2;
                end
            end
        end
    endtask

    task automatic do_cycle(input bit rn, input bit sv, input logic [127:0] sd,
                            input bit kv, input logic [31:0] kd);
        resetn   = rn;
        st_valid = sv;
        st_data  = sd;
        kw_valid = kv;
        kw_data  = kd;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

        resetn   = 1'b0;
        st_valid = 1'b0;
        kw_valid = 1'b0;
        st_data  = '0;
        kw_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        cyc     = 0;
        free_at = 0;
        model_reset();

        // All-zero state, then the data changes right after acceptance.
        do_cycle(1'b1, 1'b1, 128'd0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, rnd128(), 1'b0, 32'd0);
        check("st_zero_vec", st_out, {16{8'h63}});

        do_cycle(1'b1, 1'b0, 128'd0, 1'b1, 32'h00010053);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 128'd0, 1'b0, $urandom());
        check("kw_vec", {96'd0, kw_out}, {96'd0, 32'h637C63ED});

        // Both requesters held high straight out of reset.
        do_cycle(1'b0, 1'b0, 128'd0, 1'b0, 32'd0);
        for (int i = 0; i < 24; i++) do_cycle(1'b1, 1'b1, rnd128(), 1'b1, $urandom());
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 128'd0, 1'b0, 32'd0);

        // Reset two cycles into a state op.
        do_cycle(1'b1, 1'b1, rnd128(), 1'b0, 32'd0);
        do_cycle(1'b1, 1'b0, 128'd0, 1'b0, 32'd0);
        do_cycle(1'b0, 1'b0, 128'd0, 1'b0, 32'd0);
        do_cycle(1'b1, 1'b0, 128'd0, 1'b0, 32'd0);
        check("st_out_after_rst", st_out, 128'd0);

        // Key word arriving one cycle after a state op starts.
        do_cycle(1'b1, 1'b1, rnd128(), 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 128'd0, 1'b1, $urandom());
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 128'd0, 1'b0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            do_cycle($urandom_range(0, 59) != 0,
                     $urandom_range(0, 9) < 6, rnd128(),
                     $urandom_range(0, 9) < 4, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
